// File: rtl/jack_fade_pkg.sv
// jack_fade_pkg
//   Shared types and constants for the jack_fade click suppressor.
//   - state_t      : sequencer states (IDLE -> CALC x4 -> COMMIT -> IDLE)
//   - DEF_*        : default parameter values
//   - gain_unity() : unity gain value for a given number of fraction bits
package jack_fade_pkg;

  localparam int DEF_W         = 16;
  localparam int DEF_GAIN_BITS = 8;
  localparam int DEF_STEP      = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic int gain_unity(input int gain_bits);
    return 1 << gain_bits;
  endfunction

endpackage

// File: rtl/jack_fade_mul.sv
// fade_mul
//   Combinational per-channel datapath, shared across channels by the top.
//   Steps the gain one STEP toward unity (jack inserted) or zero (jack absent),
//   then scales the sample by the stepped gain with an arithmetic shift.
// Ports:
//   gain   in  GAIN_BITS+1 : current unsigned gain, 0..UNITY
//   jk     in  1           : latched jack-detect bit for this channel
//   sample in  W           : signed input sample
//   g_next out GAIN_BITS+1 : stepped gain, clamped to 0..UNITY
//   result out W           : (sample * g_next) >>> GAIN_BITS, floors toward -inf
module fade_mul
  import jack_fade_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int GAIN_BITS = DEF_GAIN_BITS,
  parameter int STEP      = DEF_STEP
) (
  input  logic [GAIN_BITS:0]    gain,
  input  logic                  jk,
  input  logic signed [W-1:0]   sample,
  output logic [GAIN_BITS:0]    g_next,
  output logic signed [W-1:0]   result
);

  localparam int PW = W + GAIN_BITS + 2;
  // One bit wider than the gain so gain + STEP cannot wrap before the clamp.
  localparam logic [GAIN_BITS+1:0] UNITY_X = (GAIN_BITS+2)'(gain_unity(GAIN_BITS));
  localparam logic [GAIN_BITS+1:0] STEP_X  = (GAIN_BITS+2)'(STEP);
  localparam logic [GAIN_BITS:0]   STEP_N  = (GAIN_BITS+1)'(STEP);

  logic [GAIN_BITS+1:0] g_sum;
  logic [GAIN_BITS:0]   g_dif;
  logic signed [PW-1:0] sample_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] prod;

  always_comb begin
    g_sum = {1'b0, gain} + STEP_X;
    g_dif = gain - STEP_N;
    if (jk) begin
      g_next = (g_sum > UNITY_X) ? UNITY_X[GAIN_BITS:0] : g_sum[GAIN_BITS:0];
    end else begin
      g_next = (gain >= STEP_N) ? g_dif : '0;
    end
  end

  // Gain is zero-extended so it is always a non-negative signed operand;
  // |result| <= |sample|, so truncating back to W bits never overflows.
  always_comb begin
    sample_ext = {{(PW-W){sample[W-1]}}, sample};
    gain_ext   = {{(PW-GAIN_BITS-1){1'b0}}, g_next};
    prod       = sample_ext * gain_ext;
    result     = W'(prod >>> GAIN_BITS);
  end

endmodule

// File: rtl/jack_fade.sv
// jack_fade
//   Input-side click suppressor. Per channel, ramps a gain toward unity while
//   the jack is inserted and toward zero while absent. One fade_mul is shared
//   across the 4 channels (one channel per CALC cycle); all 4 results are
//   presented together in COMMIT. Latency from the sample_clk rise is 6 clk.
// Ports:
//   clk            in  1 : system clock
//   rst_n          in  1 : synchronous active-low reset
//   sample_clk     in  1 : sample strobe level; each rising edge = new sample
//   sample_in0..3  in  W : signed calibrated input samples
//   jack           in  8 : bit i = jack i inserted (bits 7:4 ignored)
//   sample_out0..3 out W : signed faded samples, updated only in COMMIT
//
// Handshake: there is none. A rise is accepted only in IDLE; a rise seen in
// CALC or COMMIT is dropped without queueing and without touching the gains.
module jack_fade
  import jack_fade_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int GAIN_BITS = DEF_GAIN_BITS,
  parameter int STEP      = DEF_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  input  logic [7:0]          jack,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3
);

  state_t state;
  state_t next_state;

  logic                sc_q;
  logic                rise;
  logic [1:0]          ch;
  logic signed [W-1:0] in_lat [4];
  logic [3:0]          jk_lat;
  logic [GAIN_BITS:0]  gain   [4];
  logic signed [W-1:0] shadow [4];

  logic                latch_en;
  logic                calc_en;
  logic                commit_en;

  logic [GAIN_BITS:0]  g_next;
  logic signed [W-1:0] mul_result;

  // Upper jack bits belong to outputs and are deliberately ignored here.
  logic                jack_hi_unused;
  assign jack_hi_unused = ^jack[7:4];

  assign rise = sample_clk & ~sc_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    next_state = state;
    latch_en   = 1'b0;
    calc_en    = 1'b0;
    commit_en  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          latch_en   = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        calc_en = 1'b1;
        if (ch == 2'd3) next_state = COMMIT;
      end
      COMMIT: begin
        commit_en  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  fade_mul #(
    .W         (W),
    .GAIN_BITS (GAIN_BITS),
    .STEP      (STEP)
  ) u_mul (
    .gain   (gain[ch]),
    .jk     (jk_lat[ch]),
    .sample (in_lat[ch]),
    .g_next (g_next),
    .result (mul_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // sc_q resets high so a strobe held high across reset release is not a rise.
      sc_q        <= 1'b1;
      ch          <= 2'd0;
      jk_lat      <= 4'd0;
      sample_out0 <= '0;
      sample_out1 <= '0;
      sample_out2 <= '0;
      sample_out3 <= '0;
      for (int i = 0; i < 4; i++) begin
        in_lat[i] <= '0;
        gain[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      sc_q <= sample_clk;
      if (latch_en) begin
        in_lat[0] <= sample_in0;
        in_lat[1] <= sample_in1;
        in_lat[2] <= sample_in2;
        in_lat[3] <= sample_in3;
        jk_lat    <= jack[3:0];
        ch        <= 2'd0;
      end
      if (calc_en) begin
        gain[ch]   <= g_next;
        shadow[ch] <= mul_result;
        ch         <= ch + 2'd1;
      end
      if (commit_en) begin
        sample_out0 <= shadow[0];
        sample_out1 <= shadow[1];
        sample_out2 <= shadow[2];
        sample_out3 <= shadow[3];
      end
    end
  end

endmodule

// File: tb/tb_jack_fade.sv
// tb_jack_fade
//   Directed bench for jack_fade. Drivers push the expected 4-channel output
//   word and its due cycle into exp_q; a negedge monitor pops and compares at
//   the due cycle and checks the outputs stay constant on every other cycle.
module tb_jack_fade;

  localparam int W     = 16;
  localparam int GB    = 8;
  localparam int STEP  = 1;
  localparam int UNITY = 256;

  typedef struct packed {
    int          cyc;
    logic [63:0] data;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                sample_clk;
  logic signed [W-1:0] sample_in0, sample_in1, sample_in2, sample_in3;
  logic [7:0]          jack;
  logic signed [W-1:0] sample_out0, sample_out1, sample_out2, sample_out3;
  logic [63:0]         outs;

  assign outs = {sample_out3, sample_out2, sample_out1, sample_out0};

  jack_fade #(.W(W), .GAIN_BITS(GB), .STEP(STEP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_clk  (sample_clk),
    .sample_in0  (sample_in0),
    .sample_in1  (sample_in1),
    .sample_in2  (sample_in2),
    .sample_in3  (sample_in3),
    .jack        (jack),
    .sample_out0 (sample_out0),
    .sample_out1 (sample_out1),
    .sample_out2 (sample_out2),
    .sample_out3 (sample_out3)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  exp_t        exp_q[$];
  logic [63:0] cur_exp = '0;
  int          m_gain [4];
  logic signed [W-1:0] in_v [4];
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Reference model: step gain toward unity/zero, then floor-scale the input.
  task automatic push_expect(input logic [7:0] jk, input int due);
    exp_t   e;
    longint p;
    e.cyc  = due;
    e.data = '0;
    for (int i = 0; i < 4; i++) begin
      if (jk[i]) m_gain[i] = (m_gain[i] + STEP > UNITY) ? UNITY : m_gain[i] + STEP;
      else       m_gain[i] = (m_gain[i] < STEP) ? 0 : m_gain[i] - STEP;
      p = longint'(in_v[i]) * longint'(m_gain[i]);
      p = p >>> GB;
      e.data[i*16 +: 16] = p[15:0];
    end
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        cur_exp = e.data;
        check("commit", outs, e.data);
      end else begin
        check("hold", outs, cur_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs(input logic [7:0] jk);
    sample_in0 = in_v[0];
    sample_in1 = in_v[1];
    sample_in2 = in_v[2];
    sample_in3 = in_v[3];
    jack       = jk;
  endtask

  // One sample: rise latched at edge c+1, jack changed to jk_mid mid-CALC,
  // outputs due after edge c+6. Strobe period is 7 clk.
  task automatic send(input logic [7:0] jk, input logic [7:0] jk_mid);
    int c;
    tick();
    c = cyc;
    drive_inputs(jk);
    sample_clk = 1'b1;
    push_expect(jk, c + 6);
    tick();
    tick();
    jack = jk_mid;
    tick();
    sample_clk = 1'b0;
    repeat (3) tick();
  endtask

  // Second rise during CALC (dropped), third rise 10 cycles after the first.
  task automatic send_drop(input logic [7:0] jk);
    int c;
    tick();
    c = cyc;
    drive_inputs(jk);
    sample_clk = 1'b1;
    push_expect(jk, c + 6);
    tick();
    sample_clk = 1'b0;
    tick();
    tick();
    sample_clk = 1'b1;
    tick();
    tick();
    sample_clk = 1'b0;
    repeat (5) tick();
    c = cyc;
    sample_clk = 1'b1;
    push_expect(jk, c + 6);
    repeat (3) tick();
    sample_clk = 1'b0;
    repeat (3) tick();
  endtask

  task automatic clear_model();
    exp_q.delete();
    cur_exp = '0;
    for (int i = 0; i < 4; i++) m_gain[i] = 0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    clear_model();
    tick();
    check("reset_out", outs, 64'd0);
    mon_en = 1'b1;
  endtask

  // Reset asserted mid-CALC with sample_clk held high through release.
  task automatic mid_reset();
    int c;
    tick();
    c = cyc;
    drive_inputs(8'h0F);
    sample_clk = 1'b1;
    repeat (3) tick();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    tick();
    check("rst_next", outs, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_hold", outs, 64'd0);
    end
    clear_model();
    mon_en = 1'b1;
    sample_clk = 1'b0;
    tick();
    tick();
    if (c < 0) $display("unexpected cycle %0d", c);
  endtask

  task automatic set_in(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                        input logic signed [W-1:0] d, input logic signed [W-1:0] e);
    in_v[0] = a;
    in_v[1] = b;
    in_v[2] = d;
    in_v[3] = e;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst_n      = 1'b0;
    sample_clk = 1'b0;
    jack       = 8'h0F;
    set_in(16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000);
    drive_inputs(8'h0F);
    do_reset();

    // Fade-in from reset: first commit is 1000*1>>8 = 3 on every channel.
    send(8'h0F, 8'h0F);
    // Dropped rise: gains advance once (2), then the E+10 rise gives gain 3.
    send_drop(8'h0F);
    // Jack 0 pulled mid-CALC: this sample still ramps up, the next ramps down.
    send(8'h0F, 8'h0E);
    send(8'h0E, 8'h0E);
    guard = 0;
    while ((m_gain[0] < UNITY || m_gain[3] < UNITY) && guard < 600) begin
      send(8'h0F, 8'h0F);
      guard++;
    end
    send(8'h0F, 8'h0F);
    send(8'h0F, 8'h0F);

    // Passthrough at unity, including full-scale extremes on channel 2.
    set_in(16'sd1000, 16'sd1000, 16'sh7FFF, 16'sd1000);
    send(8'h0F, 8'h0F);
    set_in(16'sd1000, 16'sd1000, 16'sh8000, 16'sd1000);
    send(8'h0F, 8'h0F);
    set_in(-16'sd1234, 16'sd5, 16'sh7FFF, 16'sh8000);
    send(8'h0F, 8'h0F);
    set_in(16'sd0, -16'sd1, 16'sh8000, 16'sh7FFF);
    send(8'h0F, 8'h0F);

    // Unplug jack 0 (upper jack bits set, must be ignored): -1 then 0.
    set_in(-16'sd1, 16'sd1234, -16'sd5, 16'sh4000);
    repeat (258) send(8'hAE, 8'hAE);

    // Reset mid-CALC with gains at 128.
    set_in(16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000);
    do_reset();
    repeat (128) send(8'h0F, 8'h0F);
    mid_reset();
    send(8'h0F, 8'h0F);
    send(8'h0F, 8'h0F);

    repeat (10) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
